// File: rtl/spi_word_sequencer_if.sv
// Word-level link between spi_word_sequencer (master modport) and the SPI master word engine.
interface spi_word_sequencer_if #(
   parameter int unsigned WORD_W = 16
) ();
   logic              start;
   logic [WORD_W-1:0] d_tx;
   logic              ready;
   logic [WORD_W-1:0] d_rx;

   modport master (output start, output d_tx, input ready, input d_rx);
   modport slave  (input start, input d_tx, output ready, output d_rx);
endinterface

// File: rtl/spi_word_sequencer.sv
// Buffers host TX words, issues one SPI master transaction per word and captures RX words.
// Optional watchdog on the master's ready pulse is enabled by defining SPI_SEQ_TIMEOUT_EN.
module spi_word_sequencer #(
   parameter int unsigned DEPTH_LOG2     = 3,
   parameter int unsigned WORD_W         = 16,
   parameter int unsigned GAP_CYCLES     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [WORD_W-1:0]     wr_data,
   output logic                  tx_full,
   output logic [DEPTH_LOG2:0]   tx_level,
   output logic                  wr_drop,
   input  logic                  rd_en,
   output logic [WORD_W-1:0]     rd_data,
   output logic                  rx_empty,
   output logic [DEPTH_LOG2:0]   rx_level,
   spi_word_sequencer_if.master  spi,
   output logic                  busy,
   output logic                  timeout
);
   localparam int unsigned           Depth   = 1 << DEPTH_LOG2;
   localparam int unsigned           LvlW    = DEPTH_LOG2 + 1;
   localparam logic [LvlW-1:0]       LvlFull = LvlW'(Depth);
   localparam logic [LvlW-1:0]       LvlOne  = LvlW'(1);
   localparam logic [DEPTH_LOG2-1:0] PtrOne  = DEPTH_LOG2'(1);
   localparam logic [7:0]            GapLoad = 8'(GAP_CYCLES);

   if (GAP_CYCLES > 255 || TIMEOUT_CYCLES == 0) begin : g_bad_params
      $error("spi_word_sequencer: GAP_CYCLES must be 0..255, TIMEOUT_CYCLES nonzero");
   end

   typedef enum logic [1:0] {StIdle, StWaitRdy, StGap} state_e;

   state_e                state_q, state_d;
   logic [7:0]            gap_q, gap_d;
   logic [WORD_W-1:0]     d_tx_q, d_tx_d;
   logic                  ready_prev_q;
   logic                  wr_drop_q, wr_drop_d;

   logic [WORD_W-1:0]     tx_mem_q [Depth];
   logic [DEPTH_LOG2-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
   logic [LvlW-1:0]       tx_level_q, tx_level_d;

   logic [WORD_W-1:0]     rx_mem_q [Depth];
   logic [DEPTH_LOG2-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
   logic [LvlW-1:0]       rx_level_q, rx_level_d;

   logic tx_push, tx_pop, rx_push, rx_pop, rx_full;
   logic ready_rise, to_expire, can_start;

   assign tx_full    = (tx_level_q == LvlFull);
   assign rx_full    = (rx_level_q == LvlFull);
   assign rx_empty   = (rx_level_q == '0);
   assign ready_rise = spi.ready & ~ready_prev_q;
   // A full RX FIFO holds off new transactions so a received word always has a slot.
   assign can_start  = (state_q == StIdle) && (tx_level_q != '0) && !rx_full && !reset;

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      d_tx_d  = d_tx_q;
      tx_pop  = 1'b0;
      rx_push = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (can_start) begin
               tx_pop  = 1'b1;
               d_tx_d  = tx_mem_q[tx_rd_ptr_q];
               state_d = StWaitRdy;
            end
         end
         StWaitRdy: begin
            if (ready_rise) begin
               rx_push = 1'b1;
               gap_d   = GapLoad;
               state_d = StGap;
            end else if (to_expire) begin
               gap_d   = GapLoad;
               state_d = StGap;
            end
         end
         StGap: begin
            if (gap_q == '0) state_d = StIdle;
            else             gap_d   = gap_q - 8'd1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      tx_push     = wr_en && !tx_full;
      wr_drop_d   = wr_en && tx_full;
      tx_wr_ptr_d = tx_wr_ptr_q;
      tx_rd_ptr_d = tx_rd_ptr_q;
      tx_level_d  = tx_level_q;
      if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + PtrOne;
      if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + PtrOne;
      if (tx_push && !tx_pop)      tx_level_d = tx_level_q + LvlOne;
      else if (!tx_push && tx_pop) tx_level_d = tx_level_q - LvlOne;
   end

   always_comb begin
      rx_pop      = rd_en && !rx_empty;
      rx_wr_ptr_d = rx_wr_ptr_q;
      rx_rd_ptr_d = rx_rd_ptr_q;
      rx_level_d  = rx_level_q;
      if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + PtrOne;
      if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + PtrOne;
      if (rx_push && !rx_pop)      rx_level_d = rx_level_q + LvlOne;
      else if (!rx_push && rx_pop) rx_level_d = rx_level_q - LvlOne;
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem_q[tx_wr_ptr_q] <= wr_data;
      if (rx_push) rx_mem_q[rx_wr_ptr_q] <= spi.d_rx;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         gap_q        <= '0;
         d_tx_q       <= '0;
         ready_prev_q <= 1'b0;
         wr_drop_q    <= 1'b0;
         tx_wr_ptr_q  <= '0;
         tx_rd_ptr_q  <= '0;
         tx_level_q   <= '0;
         rx_wr_ptr_q  <= '0;
         rx_rd_ptr_q  <= '0;
         rx_level_q   <= '0;
      end else begin
         state_q      <= state_d;
         gap_q        <= gap_d;
         d_tx_q       <= d_tx_d;
         ready_prev_q <= spi.ready;
         wr_drop_q    <= wr_drop_d;
         tx_wr_ptr_q  <= tx_wr_ptr_d;
         tx_rd_ptr_q  <= tx_rd_ptr_d;
         tx_level_q   <= tx_level_d;
         rx_wr_ptr_q  <= rx_wr_ptr_d;
         rx_rd_ptr_q  <= rx_rd_ptr_d;
         rx_level_q   <= rx_level_d;
      end
   end

`ifdef SPI_SEQ_TIMEOUT_EN
   localparam int unsigned    ToW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);
   localparam logic [ToW-1:0] ToOne  = ToW'(1);

   logic [ToW-1:0] to_cnt_q, to_cnt_d;
   logic           timeout_q, timeout_d;

   always_comb begin
      to_cnt_d  = '0;
      timeout_d = timeout_q;
      to_expire = 1'b0;
      if (state_q == StWaitRdy && !ready_rise) begin
         if (to_cnt_q == ToLast) begin
            to_expire = 1'b1;
            timeout_d = 1'b1;
         end else begin
            to_cnt_d = to_cnt_q + ToOne;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         to_cnt_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         to_cnt_q  <= to_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign to_expire = 1'b0;
   assign timeout   = 1'b0;
`endif

   assign tx_level  = tx_level_q;
   assign rx_level  = rx_level_q;
   assign wr_drop   = wr_drop_q;
   assign rd_data   = rx_empty ? '0 : rx_mem_q[rx_rd_ptr_q];
   // The popped word is presented in the start cycle itself, then held from d_tx_q.
   assign spi.start = can_start;
   assign spi.d_tx  = can_start ? tx_mem_q[tx_rd_ptr_q] : d_tx_q;
   assign busy      = (state_q != StIdle) || can_start;
endmodule
